// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 constants, key-expansion FSM encoding and the byte-level
// helpers (GF(2^8) multiply, S-box, SubWord, Rcon) used by the RoundKey stage.
// No ports.
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_KEY_W      = 128;
  localparam int AES_NUM_ROUNDS = 10;
  localparam int AES_RND_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } ke_state_t;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // S-box computed rather than tabulated: multiplicative inverse as x^254
  // (x^2 * x^4 * ... * x^128, which also maps 0 to 0), then the affine map.
  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_byte(w[31:24]), sbox_byte(w[23:16]),
            sbox_byte(w[15:8]),  sbox_byte(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [AES_RND_W-1:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/key_expand_seq_round_key.sv
// -----------------------------------------------------------------------------
// key_expand_seq_round_key
// Combinational RoundKey stage: derives round key r from round key r-1.
// Ports:
//   key_prev_i  previous round key (word 0 in bits 127:96)
//   rnd_i       round number 1..10 (selects Rcon)
//   key_next_o  next round key
// -----------------------------------------------------------------------------
module key_expand_seq_round_key
  import aes_pkg::*;
(
  input  logic [AES_KEY_W-1:0] key_prev_i,
  input  logic [AES_RND_W-1:0] rnd_i,
  output logic [AES_KEY_W-1:0] key_next_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_prev_i;

  // RotWord then SubWord then Rcon on the top byte.
  assign t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(rnd_i), 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_next_o = {n0, n1, n2, n3};

endmodule

// File: rtl/key_expand_seq.sv
// -----------------------------------------------------------------------------
// key_expand_seq
// Sequential AES-128 key expansion: accepts a cipher key over valid/ready,
// derives one round key per clock into an 11-entry register file, then serves
// registered reads by index.
// Optional build macro: KEY_EXP_ZEROIZE_EN adds the zeroize input, which clears
// the register file and rk_out and returns the FSM to IDLE.
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   zeroize            (KEY_EXP_ZEROIZE_EN only) synchronous wipe
//   key_in/key_valid/key_ready  key handshake
//   busy, keys_valid   expansion in progress / all round keys stable
//   rd_en, rd_idx      read request and index (0..10; larger reads as zero)
//   rk_out, rd_valid   registered read data, valid for one cycle
// Handshake: a key transfers on a rising edge where key_valid and key_ready
// are both high; key_ready is high in IDLE and READY, low during EXPAND.
// -----------------------------------------------------------------------------
module key_expand_seq
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef KEY_EXP_ZEROIZE_EN
  input  logic                 zeroize,
`endif
  input  logic [AES_KEY_W-1:0] key_in,
  input  logic                 key_valid,
  output logic                 key_ready,
  output logic                 busy,
  output logic                 keys_valid,
  input  logic                 rd_en,
  input  logic [AES_RND_W-1:0] rd_idx,
  output logic [AES_KEY_W-1:0] rk_out,
  output logic                 rd_valid
);

  localparam logic [AES_RND_W-1:0] LAST_RND = AES_RND_W'(NUM_ROUNDS);

  ke_state_t              state_q, state_d;
  logic [AES_RND_W-1:0]   rnd_q, rnd_d;
  logic [AES_KEY_W-1:0]   rf_q [0:NUM_ROUNDS];
  logic [AES_KEY_W-1:0]   rk_out_q, rk_out_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   zero_req;
  logic                   accept;
  logic [AES_KEY_W-1:0]   prev_key, next_key, rd_data;

`ifdef KEY_EXP_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  // Zeroize wins over a simultaneous key handshake.
  assign accept = key_valid & key_ready & ~zero_req;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    unique case (state_q)
      IDLE, READY: begin
        if (accept) begin
          state_d = EXPAND;
          rnd_d   = 4'd1;
        end
      end
      EXPAND: begin
        // Counter parks at the last round instead of wrapping.
        if (rnd_q == LAST_RND) state_d = READY;
        else                   rnd_d   = rnd_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    if (zero_req) begin
      state_d = IDLE;
      rnd_d   = '0;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    key_ready  = 1'b0;
    busy       = 1'b0;
    keys_valid = 1'b0;
    unique case (state_q)
      IDLE:    key_ready = 1'b1;
      EXPAND:  busy      = 1'b1;
      READY: begin
        key_ready  = 1'b1;
        keys_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- Expansion datapath ----------------
  always_comb begin
    prev_key = '0;
    for (int i = 1; i <= NUM_ROUNDS; i++) begin
      if (rnd_q == AES_RND_W'(i)) prev_key = rf_q[i-1];
    end
  end

  key_expand_seq_round_key u_round_key (
    .key_prev_i (prev_key),
    .rnd_i      (rnd_q),
    .key_next_o (next_key)
  );

  // Register file has no reset; stale entries are hidden by keys_valid.
`ifdef KEY_EXP_ZEROIZE_EN
  always_ff @(posedge clk) begin
    if (zeroize) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) rf_q[i] <= '0;
    end else begin
      if (accept) rf_q[0] <= key_in;
      if (state_q == EXPAND) begin
        for (int i = 1; i <= NUM_ROUNDS; i++) begin
          if (rnd_q == AES_RND_W'(i)) rf_q[i] <= next_key;
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (accept) rf_q[0] <= key_in;
    if (state_q == EXPAND) begin
      for (int i = 1; i <= NUM_ROUNDS; i++) begin
        if (rnd_q == AES_RND_W'(i)) rf_q[i] <= next_key;
      end
    end
  end
`endif

  // ---------------- Read port ----------------
  // Reads sample the pre-edge array, so a read alongside a new key sees
  // the old contents.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (rd_idx == AES_RND_W'(i)) rd_data = rf_q[i];
    end
  end

  always_comb begin
    rd_valid_d = rd_en & keys_valid & ~zero_req;
    rk_out_d   = rd_valid_d ? rd_data : rk_out_q;
    if (zero_req) rk_out_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_out_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rk_out_q   <= rk_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rk_out   = rk_out_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_key_expand_seq.sv
// -----------------------------------------------------------------------------
// tb_key_expand_seq
// Self-checking bench for key_expand_seq. The reference key schedule is built
// from the word-recurrence form of AES key expansion, using an S-box table
// generated by walking the multiplicative group with generator 3.
// -----------------------------------------------------------------------------
module tb_key_expand_seq;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         keys_valid;
  logic         rd_en;
  logic [3:0]   rd_idx;
  logic [127:0] rk_out;
  logic         rd_valid;
`ifdef KEY_EXP_ZEROIZE_EN
  logic         zeroize;
`endif

  always #5 clk = ~clk;

  key_expand_seq dut (
    .clk        (clk),
    .rst        (rst),
`ifdef KEY_EXP_ZEROIZE_EN
    .zeroize    (zeroize),
`endif
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .rk_out     (rk_out),
    .rd_valid   (rd_valid)
  );

  int checks   = 0;
  int failures = 0;

  logic [127:0] exp_q[$];
  logic [7:0]   sbox_t [0:255];
  logic [127:0] model_rk [0:10];
  logic         model_valid = 1'b0;

  // ---------------- reference model ----------------
  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = (b << n) | (b >> (8 - n));
    return r;
  endfunction

  function automatic void build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    repeat (255) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end
    sbox_t[0] = 8'h63;
  endfunction

  function automatic void expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Monitor: every rd_valid cycle consumes one expected entry.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rd_valid actual=%h expected=no_read", rk_out);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        if (rk_out !== e) begin
          failures++;
          $display("FAIL rk_out actual=%h expected=%h", rk_out, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks are entered 1 time unit after a rising edge.
  task automatic issue_read_exp(input logic [3:0] idx, input logic [127:0] expv);
    rd_en  = 1'b1;
    rd_idx = idx;
    if (model_valid) exp_q.push_back(expv);
    @(posedge clk); #1;
    rd_en = 1'b0;
    check("rd_valid_after_read", {127'd0, rd_valid}, {127'd0, model_valid});
  endtask

  task automatic issue_read(input logic [3:0] idx);
    issue_read_exp(idx, (idx > 4'd10) ? 128'd0 : model_rk[idx]);
  endtask

  task automatic read_all();
    for (int i = 0; i <= 10; i++) issue_read(4'(i));
  endtask

  // Load a key; optionally pulse key_valid with another key glitch_cycle
  // cycles into the expansion. Checks expansion latency of 10 cycles.
  task automatic load_key(input logic [127:0] k, input int glitch_cycle, input logic [127:0] gk);
    int cnt;
    check("key_ready_before_load", {127'd0, key_ready}, 128'd1);
    key_in    = k;
    key_valid = 1'b1;
    model_valid = 1'b0;
    @(posedge clk); #1;
    key_valid = 1'b0;
    rd_en     = 1'b0;
    expand(k);
    check("busy_after_accept", {127'd0, busy}, 128'd1);
    check("key_ready_in_expand", {127'd0, key_ready}, 128'd0);
    check("keys_valid_drops", {127'd0, keys_valid}, 128'd0);
    cnt = 0;
    while (keys_valid !== 1'b1 && cnt < 20) begin
      if (glitch_cycle != 0 && cnt == glitch_cycle) begin
        check("key_ready_at_glitch", {127'd0, key_ready}, 128'd0);
        key_in    = gk;
        key_valid = 1'b1;
      end
      @(posedge clk); #1;
      key_valid = 1'b0;
      cnt++;
    end
    check("expand_latency", 128'(cnt), 128'd10);
    model_valid = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] k, k2;
    rst       = 1'b1;
    key_in    = '0;
    key_valid = 1'b0;
    rd_en     = 1'b0;
    rd_idx    = '0;
`ifdef KEY_EXP_ZEROIZE_EN
    zeroize   = 1'b0;
`endif
    build_sbox();
    repeat (2) @(posedge clk);
    #1;
    check("reset_key_ready", {127'd0, key_ready}, 128'd1);
    check("reset_busy", {127'd0, busy}, 128'd0);
    check("reset_keys_valid", {127'd0, keys_valid}, 128'd0);
    check("reset_rd_valid", {127'd0, rd_valid}, 128'd0);
    check("reset_rk_out", rk_out, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero key, known round-1 value.
    load_key(128'd0, 0, 128'd0);
    issue_read_exp(4'd1, 128'h62636363_62636363_62636363_62636363);

    // FIPS-197 key, back-to-back reads of every entry.
    k = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    load_key(k, 0, 128'd0);
    issue_read_exp(4'd0, k);
    issue_read_exp(4'd1, 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    for (int i = 2; i <= 9; i++) issue_read(4'(i));
    issue_read_exp(4'd10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);

    // key_valid pulsed during expansion must be ignored.
    k  = {$urandom(), $urandom(), $urandom(), $urandom()};
    k2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    load_key(k, 4, k2);
    read_all();

    // Read of entry 10 on the same edge a new key is accepted.
    exp_q.push_back(model_rk[10]);
    rd_en  = 1'b1;
    rd_idx = 4'd10;
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    load_key(k, 0, 128'd0);
    read_all();

    // Out-of-range indices read as zero.
    issue_read(4'd15);
    issue_read(4'd11);
    issue_read(4'd3);

    // Asynchronous reset in the middle of an expansion.
    key_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid   = 1'b0;
    model_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_key_ready", {127'd0, key_ready}, 128'd1);
    check("midrst_busy", {127'd0, busy}, 128'd0);
    check("midrst_keys_valid", {127'd0, keys_valid}, 128'd0);
    check("midrst_rd_valid", {127'd0, rd_valid}, 128'd0);
    check("midrst_rk_out", rk_out, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue_read(4'd2);
    check("rk_out_holds_after_ignored_read", rk_out, 128'd0);

    // Randomized keys and reads.
    for (int n = 0; n < 4; n++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      load_key(k, 0, 128'd0);
      for (int j = 0; j < 10; j++) begin
        issue_read(4'($urandom_range(0, 15)));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end
    end

`ifdef KEY_EXP_ZEROIZE_EN
    zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize     = 1'b0;
    model_valid = 1'b0;
    check("zeroize_keys_valid", {127'd0, keys_valid}, 128'd0);
    check("zeroize_rk_out", rk_out, 128'd0);
    check("zeroize_key_ready", {127'd0, key_ready}, 128'd1);
    issue_read(4'd0);
    load_key(128'd0, 0, 128'd0);
    issue_read_exp(4'd0, 128'd0);
    issue_read(4'd10);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_expand_seq.md
Name: key_expand_seq

Overview:
Sequential AES-128 key-expansion engine that sits directly upstream of the cipher round datapath. It accepts a 128-bit cipher key over a valid/ready handshake. It iterates the existing RoundKey combinational stage once per clock for rounds 1..10 and stores all 11 round keys in an internal register file. The round datapath then reads keys by index through a registered read port.

Parameters:
NUM_ROUNDS, 10, number of expansion rounds; the register file holds NUM_ROUNDS+1 entries. Only 10 is supported.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
key_in  in  128  cipher key (round-0 key)
key_valid  in  1  key_in is valid
key_ready  out  1  engine can accept a key
busy  out  1  expansion in progress
keys_valid  out  1  all 11 round keys are stored and stable
rd_en  in  1  read request
rd_idx  in  4  round-key index, 0..10
rk_out  out  128  registered round key
rd_valid  out  1  rk_out updated this cycle
zeroize  in  1  present only with KEY_EXP_ZEROIZE_EN

Behaviour:
- Reset state: IDLE; key_ready=1; busy=0; keys_valid=0; rd_valid=0; rk_out=0; round counter=0; register file is not cleared.
- FSM states are IDLE, EXPAND and READY.
- IDLE: key_ready=1. When key_valid&key_ready: write key_in to entry 0, set round counter=1, go to EXPAND.
- EXPAND: key_ready=0, busy=1.
  - Each cycle, write entry[r] = RoundKey(entry[r-1], r), where r is the 4-bit counter.
  - When r=10, the write completes, then go to READY; otherwise r=r+1.
- Latency: the key handshake occurs on edge 0, and keys_valid is high after edge 10 (10 cycles).
- READY: keys_valid=1, key_ready=1, busy=0.
  - A new key_valid&key_ready accepts the key, overwrites entry 0 and goes to EXPAND.
  - keys_valid drops on the same edge.
- key_valid is ignored while in EXPAND, because key_ready=0.
- Read port:
  - rd_en&keys_valid: on the next edge, rk_out=entry[rd_idx] and rd_valid=1 for one cycle.
  - rd_idx>10 returns all-zero, still with rd_valid=1.
  - rd_en while keys_valid=0 is ignored: rd_valid=0 and rk_out holds its value.
- Simultaneous read and new key in READY: the read is served from the old contents (pre-edge array); the new key is accepted on the same edge.
- Back-to-back reads are allowed, one per cycle.
- Asynchronous reset mid-EXPAND returns immediately to IDLE with the reset values above. Partially expanded entries are left stale but are never readable, because keys_valid=0.
- Round counter width is 4 bits. It never exceeds 10 and does not wrap.

Optional Feature:
KEY_EXP_ZEROIZE_EN
- Defined: the zeroize port exists. When zeroize=1 on an edge:
  - all 11 entries and rk_out are cleared to 0;
  - rd_valid=0, keys_valid=0, FSM goes to IDLE;
  - zeroize has priority over key acceptance and reads;
  - zeroize during EXPAND aborts the expansion.
- Undefined: no zeroize port and no clearing logic; the register file is never cleared.

Decomposition:
- Shared package aes_pkg holds:
  - AES_KEY_W=128
  - AES_NUM_ROUNDS=10
  - round-index width 4
  - FSM state encoding ke_state_t {IDLE, EXPAND, READY}
- One sub-module: the existing RoundKey, instantiated once and driven by entry[r-1] and the counter. No new sub-module is needed.

Test Plan:
- Zero key: accept key_in=0; after 10 cycles keys_valid=1; read idx 1 -> rk_out=62636363_62636363_62636363_62636363 with rd_valid one cycle later.
- Key 2b7e151628aed2a6abf7158809cf4f3c: read idx 0..10 back-to-back -> idx 0 equals the input key, and each entry equals the RoundKey golden-model chain; rd_valid is high for 11 consecutive cycles.
- Pulse key_valid during EXPAND (cycle 4) -> key_ready=0, the key is not accepted, and results are unchanged from the first key.
- In READY, issue rd_en idx 10 together with a new key -> rk_out holds the old round-10 key, keys_valid=0 for the next 10 cycles, then the new keys are present.
- Assert rst at cycle 5 of EXPAND -> outputs return to their reset values asynchronously; a read before the next expansion yields rd_valid=0.
- rd_idx=15 in READY -> rk_out=0, rd_valid=1. With KEY_EXP_ZEROIZE_EN, zeroize in READY -> keys_valid=0, and after re-expansion a zero-key read of idx 0 returns 0.
